// File: rtl/ieee_float_pkg.sv
// Shared IEEE float types: rounding modes and the iterative-normalizer FSM encoding.
package ieee_float_pkg;

   typedef enum logic [2:0] {
      RNE = 3'd0,
      RTZ = 3'd1,
      RDN = 3'd2,
      RUP = 3'd3,
      RMM = 3'd4
   } round_mode_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      NORM = 2'd1,
      DONE = 2'd2
   } norm_state_t;

endpackage

// File: rtl/float_normalizer.sv
// Iterative one-bit-per-cycle normalizer producing the {A, sticky, exp} form the rounder consumes.
module float_normalizer
   import ieee_float_pkg::*;
#(
   parameter int unsigned N    = 24,
   parameter int unsigned W    = 2 * N,
   parameter int unsigned E    = 10,
   parameter int          EMIN = 1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              sign_in,
   input  logic [W-1:0]      mag_in,
   input  logic [E-1:0]      exp_in,
   input  round_mode_t       round_mode_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              sign,
   output logic [N-1:0]      A,
   output logic [1:0]        sticky,
   output logic [E-1:0]      exp_out,
   output round_mode_t       round_mode,
   output logic              tiny,
   output logic              zero
);

   localparam logic signed [E-1:0] EMIN_E = E'(EMIN);
   localparam logic signed [E-1:0] ONE_E  = E'(1);

   norm_state_t             r_state;
   logic [W-1:0]            r_mag;
   logic signed [E-1:0]     r_exp;
   logic                    r_sign;
   round_mode_t             r_round_mode;
   logic                    r_tiny;
   logic                    r_zero;

   logic                    w_below_emin;
   logic                    w_above_emin;

   assign w_below_emin = (r_exp < EMIN_E);
   assign w_above_emin = (r_exp > EMIN_E);

   // Handshake and rounder-facing fields are direct views of the held registers.
   assign in_ready   = (r_state == IDLE);
   assign out_valid  = (r_state == DONE);
   assign A          = r_mag[W-1 -: N];
   assign sticky     = {r_mag[W-N-1], |r_mag[W-N-2:0]};
   assign exp_out    = r_exp;
   assign sign       = r_sign;
   assign round_mode = r_round_mode;
   assign tiny       = r_tiny;
   assign zero       = r_zero;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= IDLE;
         r_mag        <= '0;
         r_exp        <= '0;
         r_sign       <= 1'b0;
         r_round_mode <= RNE;
         r_tiny       <= 1'b0;
         r_zero       <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_mag        <= mag_in;
                  r_exp        <= exp_in;
                  r_sign       <= sign_in;
                  r_round_mode <= round_mode_in;
                  r_tiny       <= 1'b0;
                  r_zero       <= 1'b0;
                  r_state      <= NORM;
               end
            end
            NORM: begin
               if (r_mag == '0) begin
                  r_zero  <= 1'b1;
                  r_exp   <= EMIN_E;
                  r_state <= DONE;
               end else if (w_below_emin && (r_mag[W-1:1] == '0)) begin
                  // Only the jammed LSB remains, so further right shifts cannot change it.
                  r_exp <= EMIN_E;
               end else if (w_below_emin) begin
                  r_mag <= {1'b0, r_mag[W-1:2], r_mag[1] | r_mag[0]};
                  r_exp <= r_exp + ONE_E;
               end else if (!r_mag[W-1] && w_above_emin) begin
                  r_mag <= r_mag << 1;
                  r_exp <= r_exp - ONE_E;
               end else begin
                  r_tiny  <= ~r_mag[W-1];
                  r_state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_float_normalizer.sv
// Directed bench for float_normalizer at N=4, W=8, E=6, EMIN=1 with hand-computed results.
module tb_float_normalizer;
   import ieee_float_pkg::*;

   logic        clock;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic        sign_in;
   logic [7:0]  mag_in;
   logic [5:0]  exp_in;
   round_mode_t round_mode_in;
   logic        out_valid;
   logic        out_ready;
   logic        sign;
   logic [3:0]  A;
   logic [1:0]  sticky;
   logic [5:0]  exp_out;
   round_mode_t round_mode;
   logic        tiny;
   logic        zero;

   int total = 0;
   int bad   = 0;

   float_normalizer #(.N(4), .W(8), .E(6), .EMIN(1)) dut (
      .clock(clock), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .sign_in(sign_in), .mag_in(mag_in), .exp_in(exp_in), .round_mode_in(round_mode_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .sign(sign), .A(A), .sticky(sticky), .exp_out(exp_out),
      .round_mode(round_mode), .tiny(tiny), .zero(zero)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Present one operand for a single acceptance edge, then measure cycles to out_valid.
   task automatic run_op(input string tag, input logic s, input logic [7:0] m,
                         input logic [5:0] e, input round_mode_t rm, input int exp_lat);
      int lat;
      lat = 0;
      @(negedge clock);
      sign_in = s; mag_in = m; exp_in = e; round_mode_in = rm; in_valid = 1'b1;
      @(posedge clock);
      #1 in_valid = 1'b0;
      while (!out_valid && lat < 40) begin
         @(posedge clock);
         #1 lat++;
      end
      chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
   endtask

   task automatic check_out(input string tag, input logic [3:0] ea, input logic [1:0] es,
                            input logic [5:0] ee, input logic et, input logic ez);
      chk({tag, "_A"}, 32'(A), 32'(ea));
      chk({tag, "_sticky"}, 32'(sticky), 32'(es));
      chk({tag, "_exp"}, 32'(exp_out), 32'(ee));
      chk({tag, "_tiny"}, 32'(tiny), 32'(et));
      chk({tag, "_zero"}, 32'(zero), 32'(ez));
   endtask

   task automatic handoff(input string tag);
      @(negedge clock);
      out_ready = 1'b1;
      @(posedge clock);
      #1 out_ready = 1'b0;
      chk({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
      chk({tag, "_out_valid_after"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      sign_in = 1'b0; mag_in = '0; exp_in = '0; round_mode_in = RNE;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_A", 32'(A), 32'd0);
      chk("rst_exp", 32'(exp_out), 32'd0);
      chk("rst_round_mode", 32'(round_mode), 32'(RNE));
      repeat (2) @(posedge clock);
      @(negedge clock) reset_n = 1'b1;
      @(negedge clock);
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // Already normal: no shifts
      run_op("t1", 1'b1, 8'b1011_0110, 6'd5, RTZ, 1);
      check_out("t1", 4'b1011, 2'b01, 6'd5, 1'b0, 1'b0);
      chk("t1_sign", 32'(sign), 32'd1);
      chk("t1_round_mode", 32'(round_mode), 32'(RTZ));
      handoff("t1");

      // Three left shifts, then backpressure in DONE
      run_op("t2", 1'b0, 8'b0001_0110, 6'd10, RUP, 4);
      check_out("t2", 4'b1011, 2'b00, 6'd7, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clock);
         #1;
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_A", 32'(A), 32'b1011);
         chk("bp_exp", 32'(exp_out), 32'd7);
      end
      chk("t2_round_mode", 32'(round_mode), 32'(RUP));
      handoff("t2");

      // One left shift stops at EMIN, subnormal
      run_op("t3", 1'b0, 8'b0001_0110, 6'd2, RNE, 2);
      check_out("t3", 4'b0010, 2'b11, 6'd1, 1'b1, 1'b0);
      handoff("t3");

      // Two jamming right shifts up to EMIN
      run_op("t4", 1'b0, 8'b1000_0011, 6'h3F, RNE, 3);
      check_out("t4", 4'b0010, 2'b01, 6'd1, 1'b1, 1'b0);
      handoff("t4");

      // Zero magnitude
      run_op("t5", 1'b1, 8'b0000_0000, 6'b101100, RDN, 1);
      check_out("t5", 4'b0000, 2'b00, 6'd1, 1'b0, 1'b1);
      handoff("t5");

      // Lone LSB below EMIN: single clamp step
      run_op("t6", 1'b0, 8'b0000_0001, 6'b111101, RNE, 2);
      check_out("t6", 4'b0000, 2'b01, 6'd1, 1'b1, 1'b0);
      handoff("t6");

      // One jamming right shift then clamp
      run_op("t7", 1'b0, 8'b0000_0011, 6'b111011, RNE, 3);
      check_out("t7", 4'b0000, 2'b01, 6'd1, 1'b1, 1'b0);
      handoff("t7");

      // exp already at EMIN with MSB clear: no shift, tiny
      run_op("t8", 1'b0, 8'b0100_0000, 6'd1, RMM, 1);
      check_out("t8", 4'b0100, 2'b00, 6'd1, 1'b1, 1'b0);
      handoff("t8");

      // Reset asserted mid-NORM
      @(negedge clock);
      sign_in = 1'b1; mag_in = 8'b0001_0110; exp_in = 6'd10; round_mode_in = RUP; in_valid = 1'b1;
      @(posedge clock);
      #1 in_valid = 1'b0;
      chk("mid_in_ready_norm", 32'(in_ready), 32'd0);
      @(posedge clock);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      chk("mid_rst_A", 32'(A), 32'd0);
      chk("mid_rst_sign", 32'(sign), 32'd0);
      @(negedge clock) reset_n = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      chk("post_rst_idle", 32'(in_ready), 32'd1);
      chk("post_rst_no_valid", 32'(out_valid), 32'd0);

      run_op("t9", 1'b0, 8'b1011_0110, 6'd5, RNE, 1);
      check_out("t9", 4'b1011, 2'b01, 6'd5, 1'b0, 1'b0);
      handoff("t9");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
